// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: turns per-stage stall requests into a cumulative stall vector
// and sequences flush plus PC reload for exceptions and branch redirects.
module pipeline_controller #(
    parameter int STAGES        = 5,
    parameter int ADDR_WIDTH    = 32,
    parameter int FLUSH_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAGES-1:0]     stall_req,
    input  logic                  exc_req,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  redirect_req,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [STAGES-1:0]     stall_out,
    output logic                  flush_out,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  busy,
    output logic                  stall_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    localparam int CNT_W = 4;
    localparam int WD_W  = 16;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(STALL_TIMEOUT);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WD_W-1:0]       r_wd;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] r_pc_target;
    logic                  r_timeout;

    logic [1:0]            w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [WD_W-1:0]       w_wd_next;
    logic [ADDR_WIDTH-1:0] w_target_next;
    logic                  w_enter_flush;
    logic                  w_idle;
    logic                  w_any_stall;
    logic [STAGES-1:0]     w_suffix_or;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_any_stall = (stall_req != '0);

    // A stalled stage freezes itself and every younger stage behind it.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stall
            assign w_suffix_or[gi] = |(stall_req >> gi);
        end
    endgenerate

    assign stall_out = w_idle ? w_suffix_or : '0;
    assign flush_out = (r_state == ST_FLUSH);
    assign pc_load   = (r_state == ST_LOAD);
    assign busy      = !w_idle;
    assign pc_target = r_pc_target;
    assign stall_timeout = r_timeout;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_target_next = r_target;
        w_enter_flush = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exc_req) begin
                    w_enter_flush = 1'b1;
                    w_target_next = exc_target;
                end else if (redirect_req) begin
                    w_enter_flush = 1'b1;
                    w_target_next = redirect_target;
                end
            end
            ST_FLUSH: begin
                if (exc_req) begin
                    w_enter_flush = 1'b1;
                    w_target_next = exc_target;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                // Redirects are dropped here; only an exception can restart the sequence.
                if (exc_req) begin
                    w_enter_flush = 1'b1;
                    w_target_next = exc_target;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_enter_flush) begin
            w_state_next = ST_FLUSH;
            w_cnt_next   = FLUSH_INIT;
        end
    end

    always_comb begin
        w_wd_next = r_wd;
        if (w_enter_flush || !w_any_stall) begin
            w_wd_next = '0;
        end else if (w_idle && (r_wd != WD_LIMIT)) begin
            w_wd_next = r_wd + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wd        <= '0;
            r_target    <= '0;
            r_pc_target <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_wd     <= w_wd_next;
            r_target <= w_target_next;
            if ((r_state == ST_FLUSH) && (w_state_next == ST_LOAD)) begin
                r_pc_target <= r_target;
            end
            if (w_wd_next == WD_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: a cycle-level reference model predicts outputs,
// pc_load transactions are queued at stimulus time and popped by an independent monitor.
module tb_pipeline_controller;

    localparam int ST = 5;
    localparam int AW = 32;
    localparam int FC = 2;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [ST-1:0] stall_req;
    logic          exc_req;
    logic [AW-1:0] exc_target;
    logic          redirect_req;
    logic [AW-1:0] redirect_target;
    logic [ST-1:0] stall_out;
    logic          flush_out;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic          busy;
    logic          stall_timeout;

    always #5 clk = ~clk;

    pipeline_controller #(
        .STAGES(ST), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .exc_req(exc_req), .exc_target(exc_target),
        .redirect_req(redirect_req), .redirect_target(redirect_target),
        .stall_out(stall_out), .flush_out(flush_out), .pc_load(pc_load),
        .pc_target(pc_target), .busy(busy), .stall_timeout(stall_timeout)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_load = 0;

    // Reference model: cycles left in the flush+load sequence, not a state encoding.
    int            m_left;
    int            m_wd;
    bit            m_to;
    logic [AW-1:0] m_pend;
    logic [AW-1:0] m_pc;

    logic          p_rst = 1'b0;
    logic [ST-1:0] p_s;
    logic          p_e, p_r;
    logic [AW-1:0] p_et, p_rt;

    logic [ST-1:0] e_stall;
    bit            e_flush, e_load, e_busy, e_to;
    logic [AW-1:0] e_pc;
    logic [AW-1:0] q_load[$];
    bit            chk_en = 1'b0;

    function automatic void model_reset();
        m_left = 0;
        m_wd   = 0;
        m_to   = 1'b0;
        m_pend = '0;
        m_pc   = '0;
    endfunction

    function automatic void model_edge();
        bit idle;
        bit enter;
        idle  = (m_left == 0);
        enter = p_e || (p_r && idle);
        if (enter || p_s == '0) m_wd = 0;
        else if (idle && m_wd < TO) m_wd = m_wd + 1;
        if (m_wd == TO) m_to = 1'b1;
        if (p_e) begin
            m_pend = p_et;
            m_left = FC + 1;
        end else if (p_r && idle) begin
            m_pend = p_rt;
            m_left = FC + 1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
        if (m_left == 1) m_pc = m_pend;
    endfunction

    task automatic cycle(input logic r_n, input logic [ST-1:0] s, input logic e,
                         input logic [AW-1:0] et, input logic r, input logic [AW-1:0] rt);
        @(negedge clk);
        if (p_rst) model_edge();
        rst = r_n; stall_req = s; exc_req = e; exc_target = et;
        redirect_req = r; redirect_target = rt;
        p_rst = r_n; p_s = s; p_e = e; p_et = et; p_r = r; p_rt = rt;
        if (!r_n) model_reset();
        for (int i = 0; i < ST; i++) e_stall[i] = (m_left == 0) && ((s >> i) != '0);
        e_flush = (m_left > 1);
        e_load  = (m_left == 1);
        e_busy  = (m_left > 0);
        e_to    = m_to;
        e_pc    = m_pc;
        if (e_load) q_load.push_back(m_pend);
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, '0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    initial begin : monitor
        logic [AW-1:0] t;
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                check("stall_out", 64'(stall_out), 64'(e_stall));
                check("flush_out", 64'(flush_out), 64'(e_flush));
                check("pc_load", 64'(pc_load), 64'(e_load));
                check("busy", 64'(busy), 64'(e_busy));
                check("stall_timeout", 64'(stall_timeout), 64'(e_to));
                check("pc_target_hold", 64'(pc_target), 64'(e_pc));
                if (pc_load === 1'b1) begin
                    if (q_load.size() == 0) begin
                        check("pc_load_unexpected", 64'(pc_target), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        t = q_load.pop_front();
                        n_load++;
                        $display("load %0d: pc_target=0x%08h expected=0x%08h", n_load, pc_target, t);
                        check("pc_load_target", 64'(pc_target), 64'(t));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [ST-1:0] s;
        rst = 1'b0; stall_req = '0; exc_req = 1'b0; exc_target = '0;
        redirect_req = 1'b0; redirect_target = '0;
        model_reset();
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle(2);
        // Middle stage stall propagates to younger stages
        repeat (3) cycle(1'b1, 5'b00100, 1'b0, '0, 1'b0, '0);
        idle(2);
        cycle(1'b1, '0, 1'b0, '0, 1'b1, 32'h0040_0010);
        idle(5);
        cycle(1'b1, '0, 1'b1, 32'hBFC0_0380, 1'b1, 32'h0000_1000);
        idle(5);
        // Exception landing during the first flush cycle restarts the flush
        cycle(1'b1, '0, 1'b0, '0, 1'b1, 32'h0000_2000);
        cycle(1'b1, '0, 1'b1, 32'h8000_0180, 1'b0, '0);
        idle(6);
        repeat (6) cycle(1'b1, 5'b10000, 1'b0, '0, 1'b0, '0);
        idle(3);
        cycle(1'b1, '0, 1'b0, '0, 1'b1, 32'h0000_1234);
        idle(1);
        repeat (2) cycle(1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle(6);
        for (int k = 0; k < 3000; k++) begin
            s = ($urandom_range(0, 1) == 0) ? ST'($urandom) : '0;
            cycle(($urandom_range(0, 79) != 0), s,
                  ($urandom_range(0, 19) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), $urandom);
        end
        idle(6);
        @(negedge clk);
        #4;
        chk_en = 1'b0;
        check("load_queue_drained", 64'(q_load.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
